fetch_unit: RTL

- Instruction fetch stage that sits directly upstream of the decode/control stage.
- Holds the architectural PC and issues requests on a request/grant/response instruction-memory port.
- Presents the fetched word to decode with a valid/ready handshake.
- Uses the PC-select result from control (PC_4 / PC_ALU) to pick the next PC when the current instruction retires.

---
 rtl/fetch_unit.sv | 64 ++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage; one outstanding imem request, valid/ready handoff to decode,
// next PC from control's PC-select on retire, halts sticky on a misaligned target.
module fetch_unit #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_gnt,
  input  logic            i_imem_rvalid,
  input  logic [XLEN-1:0] i_imem_rdata,
  output logic [XLEN-1:0] o_inst,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc4,
  output logic            o_inst_vld,
  input  logic            i_inst_rdy,
  input  logic            i_pc_sel,
  input  logic [XLEN-1:0] i_alu_res,
  output logic            o_misalign
);
  localparam logic [2:0] S_IDLE = 3'd0, S_REQ = 3'd1, S_WAIT = 3'd2, S_HOLD = 3'd3, S_HALT = 3'd4;
  localparam logic PC_4 = 1'b0;
  logic [2:0] state;
  logic [XLEN-1:0] pc, inst, next_pc;
  logic misalign;
  // JALR semantics: bit 0 of the target is always cleared
  assign next_pc = (i_pc_sel == PC_4 ? pc + XLEN'(4) : i_alu_res) & ~XLEN'(1);
  assign o_imem_req = state == S_REQ;
  assign o_imem_addr = pc;
  assign o_inst = inst;
  assign o_pc = pc;
  assign o_pc4 = pc + XLEN'(4);
  assign o_inst_vld = state == S_HOLD;
  assign o_misalign = misalign;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state <= S_IDLE;
      pc <= RESET_PC;
      inst <= 32'h0000_0013;
      misalign <= 1'b0;
    end else
      case (state)
        S_IDLE: state <= S_REQ;
        S_REQ: state <= i_imem_gnt ? S_WAIT : S_REQ;
        S_WAIT:
          if (i_imem_rvalid) begin
            inst <= i_imem_rdata;
            state <= S_HOLD;
          end
        S_HOLD:
          if (i_inst_rdy) begin
            if (next_pc[1]) begin
              misalign <= 1'b1;
              state <= S_HALT;
            end else begin
              pc <= next_pc;
              state <= S_REQ;
            end
          end
        default: state <= S_HALT;
      endcase
endmodule
